// File: rtl/adc_serial_responder.sv
// Target end of the 3-wire serial ADC link: shifts held parallel samples out on adc_sd
// in the converter's frame format, oversampling adc_clk/adc_cs in the system clock domain.
module adc_serial_responder #(
    parameter int unsigned SAMPLE_WIDTH = 12,
    parameter int unsigned LEAD_ZEROS   = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    input  logic                    adc_clk,
    input  logic                    adc_cs,
    output logic                    adc_sd,
    output logic                    adc_sd_oe,
    output logic                    sample_taken,
    output logic                    frame_done,
    output logic                    frame_abort,
    output logic [CNT_W-1:0]        overrun_count
);

    localparam int unsigned FRAME_BITS = LEAD_ZEROS + SAMPLE_WIDTH;
    localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    // Synchronizers are preset high: serial clock high, chip select deasserted.
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   clk_hist_q;
    logic                   cs_hist_q;

    logic clk_s;
    logic cs_s;
    logic clk_fall;
    logic cs_fall;
    logic cs_rise;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_sync_q <= '1;
            cs_sync_q  <= '1;
            clk_hist_q <= 1'b1;
            cs_hist_q  <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], adc_clk};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], adc_cs};
            clk_hist_q <= clk_sync_q[SYNC_STAGES-1];
            cs_hist_q  <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign clk_fall = clk_hist_q & ~clk_s;
    assign cs_fall  = cs_hist_q & ~cs_s;
    assign cs_rise  = ~cs_hist_q & cs_s;

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_WIDTH-1:0] holding_q, holding_d;
    logic                    pending_q, pending_d;
    logic [CNT_W-1:0]        overrun_q, overrun_d;
    logic                    sd_q, sd_d;
    logic                    oe_q, oe_d;
    logic                    taken_q, taken_d;
    logic                    done_q, done_d;
    logic                    abort_q, abort_d;
    logic                    load;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        load      = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    load      = 1'b1;
                    state_d   = StShift;
                    shift_d   = {{LEAD_ZEROS{1'b0}}, holding_q};
                    bit_cnt_d = '0;
                end
            end
            StShift: begin
                // A chip-select rise beats a coincident serial clock fall.
                if (cs_rise) begin
                    abort_d = 1'b1;
                    state_d = StIdle;
                end else if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    shift_d   = shift_q << 1;
                    if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (cs_rise) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Pad outputs are registered so adc_sd never glitches while driven.
        oe_d    = (state_d == StShift);
        sd_d    = oe_d & shift_d[FRAME_BITS-1];
        taken_d = load;
    end

    // Holding register: a load and a write in the same cycle keeps the new value pending.
    always_comb begin
        holding_d = holding_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (sample_valid) begin
            holding_d = sample_in;
        end
        if (load) begin
            pending_d = sample_valid;
        end else if (sample_valid) begin
            pending_d = 1'b1;
            if (pending_q && (overrun_q != '1)) begin
                overrun_d = overrun_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            holding_q <= '0;
            pending_q <= 1'b0;
            overrun_q <= '0;
            sd_q      <= 1'b0;
            oe_q      <= 1'b0;
            taken_q   <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            holding_q <= holding_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            sd_q      <= sd_d;
            oe_q      <= oe_d;
            taken_q   <= taken_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    assign adc_sd        = sd_q;
    assign adc_sd_oe     = oe_q;
    assign sample_taken  = taken_q;
    assign frame_done    = done_q;
    assign frame_abort   = abort_q;
    assign overrun_count = overrun_q;

endmodule
